k2_multi_program_runner: RTL and testbench

//  Next-generation execution harness for K2_processor. Holds NUM_PROGS writable 16x8 program banks in place of one fixed ROM.

---
 rtl/k2_exec_pkg.sv | 23 ++
 rtl/K2_processor.sv | 55 +++++
 rtl/k2_program_bank_ram.sv | 27 ++
 rtl/k2_multi_program_runner.sv | 144 ++++++++++++++
 tb/tb_k2_multi_program_runner.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/k2_exec_pkg.sv
// Shared types and constants for the K2 multi-program execution harness.
package k2_exec_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } run_state_t;

  localparam int INST_W     = 8;
  localparam int PADDR_W    = 4;
  localparam int PROG_DEPTH = 16;

  // K2 core opcodes live in instruction bits [7:4]; [3:0] is the immediate.
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDA  = 4'h1;
  localparam logic [3:0] OP_LDB  = 4'h2;
  localparam logic [3:0] OP_ADDA = 4'h3;
  localparam logic [3:0] OP_ADDB = 4'h4;
  localparam logic [3:0] OP_OUTA = 4'h5;
  localparam logic [3:0] OP_JMP  = 4'h6;

endpackage

// File: rtl/K2_processor.sv
// Minimal K2 core: Ra/Rb/Ro registers, 4-bit PC, one instruction per cycle.
module K2_processor
  import k2_exec_pkg::*;
#(
  parameter int Bits = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INST_W-1:0]  instruction_data,
  output logic [PADDR_W-1:0] ProgramAddress,
  output logic [Bits-1:0]    Ro
);

  logic [PADDR_W-1:0] pc_q, pc_d;
  logic [Bits-1:0]    ra_q, ra_d, rb_q, rb_d, ro_q, ro_d, sum;
  logic [3:0]         op, imm;

  assign op  = instruction_data[7:4];
  assign imm = instruction_data[3:0];
  assign sum = ra_q + rb_q;

  always_comb begin
    pc_d = pc_q + 1'b1;
    ra_d = ra_q;
    rb_d = rb_q;
    ro_d = ro_q;
    case (op)
      OP_LDA:  ra_d = Bits'(imm);
      OP_LDB:  rb_d = Bits'(imm);
      OP_ADDA: begin ra_d = sum; ro_d = sum; end
      OP_ADDB: begin rb_d = sum; ro_d = sum; end
      OP_OUTA: ro_d = ra_q;
      OP_JMP:  pc_d = imm;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= '0;
      ra_q <= '0;
      rb_q <= '0;
      ro_q <= '0;
    end else begin
      pc_q <= pc_d;
      ra_q <= ra_d;
      rb_q <= rb_d;
      ro_q <= ro_d;
    end
  end

  assign ProgramAddress = pc_q;
  assign Ro             = ro_q;

endmodule

// File: rtl/k2_program_bank_ram.sv
// NUM_PROGS banks of 16x8 program storage: one sync write port, one async read port.
module k2_program_bank_ram
  import k2_exec_pkg::*;
#(
  parameter int NUM_PROGS = 4,
  parameter int BANK_W    = 2
) (
  input  logic               clk,
  input  logic               we_i,
  input  logic [BANK_W-1:0]  wbank_i,
  input  logic [PADDR_W-1:0] waddr_i,
  input  logic [INST_W-1:0]  wdata_i,
  input  logic [BANK_W-1:0]  rbank_i,
  input  logic [PADDR_W-1:0] raddr_i,
  output logic [INST_W-1:0]  rdata_o
);

  // Flat storage indexed by {bank, addr}; contents are deliberately not reset.
  logic [INST_W-1:0] mem_q [NUM_PROGS*PROG_DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[{wbank_i, waddr_i}] <= wdata_i;
  end

  assign rdata_o = mem_q[{rbank_i, raddr_i}];

endmodule

// File: rtl/k2_multi_program_runner.sv
// Execution harness: banked program store, run FSM, cycle budget and result capture for one K2 core.
// Optional ro change detection (ro_chg / ro_chg_cnt) is built when K2_EXEC_RO_CHANGE_EN is defined.
module k2_multi_program_runner
  import k2_exec_pkg::*;
#(
  parameter int BITS      = 8,
  parameter int NUM_PROGS = 4,
  parameter int CNT_W     = 16,
  parameter int BANK_W    = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic [BANK_W-1:0]  ld_bank,
  input  logic [PADDR_W-1:0] ld_addr,
  input  logic [INST_W-1:0]  ld_data,
  input  logic               start,
  input  logic [BANK_W-1:0]  run_bank,
  input  logic [CNT_W-1:0]   run_len,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic [BITS-1:0]    ro,
  output logic [CNT_W-1:0]   cycles
`ifdef K2_EXEC_RO_CHANGE_EN
  ,
  output logic               ro_chg,
  output logic [CNT_W-1:0]   ro_chg_cnt
`endif
);

  localparam logic [BANK_W:0]  NPROGS = (BANK_W+1)'(NUM_PROGS);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  run_state_t         state_q, state_d;
  logic [BANK_W-1:0]  bank_q;
  logic [CNT_W-1:0]   len_q, cyc_q;
  logic [BITS-1:0]    ro_q, core_ro;
  logic               run_q, core_rst_n;
  logic [PADDR_W-1:0] paddr;
  logic [INST_W-1:0]  inst;
  logic               start_ok, last, go, stay_run, we;

  assign start_ok = start && ({1'b0, run_bank} < NPROGS);
  assign last     = (cyc_q == len_q - ONE);
  assign go       = (state_q != RUN) && (state_d == RUN);
  assign stay_run = (state_q == RUN) && (state_d == RUN);
  assign we       = ld_valid && ld_ready && ({1'b0, ld_bank} < NPROGS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // abort dominates both start and budget expiry
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (abort)         state_d = IDLE;
        else if (start_ok) state_d = RUN;
      end
      RUN: begin
        if (abort)     state_d = IDLE;
        else if (last) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q == RUN);
    done     = (state_q == DONE);
    ld_ready = (state_q != RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q  <= 1'b0;
      bank_q <= '0;
      len_q  <= ONE;
      cyc_q  <= '0;
      ro_q   <= '0;
    end else begin
      run_q <= (state_d == RUN);
      if (go) begin
        bank_q <= run_bank;
        len_q  <= (run_len == '0) ? ONE : run_len;
        cyc_q  <= '0;
      end else if (stay_run && cyc_q != '1) begin
        cyc_q <= cyc_q + ONE;
      end
      if (state_q == RUN && !abort) ro_q <= core_ro;
    end
  end

  // Core sits in reset outside RUN so each run starts at address 0 with clean registers.
  assign core_rst_n = rst_n & run_q;

  k2_program_bank_ram #(.NUM_PROGS(NUM_PROGS), .BANK_W(BANK_W)) u_ram (
    .clk     (clk),
    .we_i    (we),
    .wbank_i (ld_bank),
    .waddr_i (ld_addr),
    .wdata_i (ld_data),
    .rbank_i (bank_q),
    .raddr_i (paddr),
    .rdata_o (inst)
  );

  K2_processor #(.Bits(BITS)) u_core (
    .clk              (clk),
    .rst_n            (core_rst_n),
    .instruction_data (inst),
    .ProgramAddress   (paddr),
    .Ro               (core_ro)
  );

  assign ro     = ro_q;
  assign cycles = cyc_q;

`ifdef K2_EXEC_RO_CHANGE_EN
  logic             chg_d, chg_q;
  logic [CNT_W-1:0] chg_cnt_q;

  assign chg_d = (state_q == RUN) && !abort && (core_ro != ro_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chg_q     <= 1'b0;
      chg_cnt_q <= '0;
    end else begin
      chg_q <= chg_d;
      if (go)                            chg_cnt_q <= '0;
      else if (chg_d && chg_cnt_q != '1) chg_cnt_q <= chg_cnt_q + ONE;
    end
  end

  assign ro_chg     = chg_q;
  assign ro_chg_cnt = chg_cnt_q;
`endif

endmodule

// File: tb/tb_k2_multi_program_runner.sv
// Directed bench for k2_multi_program_runner (3 banks so bank 3 is out of range).
module tb_k2_multi_program_runner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ld_valid = 1'b0, ld_ready;
  logic [1:0]  ld_bank = '0;
  logic [3:0]  ld_addr = '0;
  logic [7:0]  ld_data = '0;
  logic        start = 1'b0, abort = 1'b0;
  logic [1:0]  run_bank = '0;
  logic [15:0] run_len = '0;
  logic        busy, done;
  logic [7:0]  ro;
  logic [15:0] cycles;
`ifdef K2_EXEC_RO_CHANGE_EN
  logic        ro_chg;
  logic [15:0] ro_chg_cnt;
`endif

  int n_chk = 0, n_err = 0;

  // Fibonacci: LDA 0, LDB 1, OUTA, ADDB, ADDA, ADDB, ADDA, JMP 5
  logic [7:0] fib_prog [8] = '{8'h10, 8'h21, 8'h50, 8'h40, 8'h30, 8'h40, 8'h30, 8'h65};
  // Odd counter: LDA 3, LDB 2, ADDA, JMP 2
  logic [7:0] odd_prog [4] = '{8'h13, 8'h22, 8'h30, 8'h62};
  // ro after k edges past start: core Ro of cycle k-1 (Fibonacci mod 256)
  int fib_k  [7] = '{5, 7, 8, 10, 11, 13, 40};
  int fib_ro [7] = '{1, 2, 3, 5, 8, 13, 17};

  always #5 clk = ~clk;

  k2_multi_program_runner #(.BITS(8), .NUM_PROGS(3), .CNT_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ld_valid (ld_valid),
    .ld_ready (ld_ready),
    .ld_bank  (ld_bank),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .start    (start),
    .run_bank (run_bank),
    .run_len  (run_len),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .ro       (ro),
    .cycles   (cycles)
`ifdef K2_EXEC_RO_CHANGE_EN
    ,
    .ro_chg     (ro_chg),
    .ro_chg_cnt (ro_chg_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] b, input logic [3:0] a, input logic [7:0] d);
    ld_valid = 1'b1; ld_bank = b; ld_addr = a; ld_data = d;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic start_run(input logic [1:0] b, input logic [15:0] len);
    start = 1'b1; run_bank = b; run_len = len;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #12;
    chk("rst_ld_ready", ld_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ro", ro, 0);
    chk("rst_cycles", cycles, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) load(2'd1, 4'(i), fib_prog[i]);
    for (int i = 0; i < 4; i++) load(2'd0, 4'(i), odd_prog[i]);

    // Fibonacci run; a write to bank 1 is attempted mid-run and must be dropped.
    start_run(2'd1, 16'd40);
    chk("fib_busy0", busy, 1);
    chk("fib_cyc0", cycles, 0);
    for (int k = 1; k <= 40; k++) begin
      tick();
      for (int j = 0; j < 7; j++)
        if (k == fib_k[j]) chk($sformatf("fib_ro_k%0d", k), ro, fib_ro[j]);
      if (k == 20) begin
        ld_valid = 1'b1; ld_bank = 2'd1; ld_addr = 4'd0; ld_data = 8'h1F;
        chk("ld_ready_run", ld_ready, 0);
      end
      if (k == 21) ld_valid = 1'b0;
      if (k == 39) begin
        chk("fib_busy39", busy, 1);
        chk("fib_cyc39", cycles, 39);
      end
    end
    chk("fib_done", done, 1);
    chk("fib_busy_end", busy, 0);
    chk("fib_cycles", cycles, 39);
    chk("ld_ready_done", ld_ready, 1);
`ifdef K2_EXEC_RO_CHANGE_EN
    chk("fib_chg_cnt", ro_chg_cnt, 24);
`endif

    // Bank 0 from DONE
    start_run(2'd0, 16'd10);
    repeat (4) tick();
    chk("odd_ro_k4", ro, 5);
    repeat (6) tick();
    chk("odd_done", done, 1);
    chk("odd_ro", ro, 11);
    chk("odd_cycles", cycles, 9);

    // Rerun bank 1: unchanged by bank 0 loads and by the blocked write
    start_run(2'd1, 16'd40);
    repeat (40) tick();
    chk("rerun_ro", ro, 17);
    chk("rerun_done", done, 1);

    // Abort at cycle 10
    start_run(2'd1, 16'd40);
    repeat (10) tick();
    chk("ab_cyc_pre", cycles, 10);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_busy", busy, 0);
    chk("ab_done", done, 0);
    chk("ab_cycles", cycles, 10);
    chk("ab_ro", ro, 5);
    tick();
    chk("ab_cycles_hold", cycles, 10);

    // abort + start together stays in IDLE
    abort = 1'b1; start = 1'b1; run_bank = 2'd1; run_len = 16'd40;
    tick();
    abort = 1'b0; start = 1'b0;
    chk("abst_busy", busy, 0);
    chk("abst_cycles", cycles, 10);

    // run_len = 0 behaves as 1
    start_run(2'd0, 16'd0);
    chk("len0_busy", busy, 1);
    tick();
    chk("len0_done", done, 1);
    chk("len0_cycles", cycles, 0);
    chk("len0_ro", ro, 0);

    // Out-of-range bank: start ignored, write port still ready
    start_run(2'd3, 16'd5);
    chk("oor_busy", busy, 0);
    chk("oor_done", done, 1);
    ld_bank = 2'd3;
    chk("oor_ld_ready", ld_ready, 1);

    // Asynchronous reset mid-run
    start_run(2'd1, 16'd40);
    repeat (12) tick();
    rst_n = 1'b0;
    #1;
    chk("mrst_ro", ro, 0);
    chk("mrst_cycles", cycles, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_ld_ready", ld_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("mrst_idle", busy | done, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
